// File: rtl/clock_pkg.sv
// ============================================================================
// clock_pkg : state encodings, BCD digit limits and widths for the HH:MM clock
// Revision  : 1.0
// ============================================================================
`default_nettype none

package clock_pkg;

    localparam int c_h1_w    = 3;
    localparam int c_h0_w    = 4;
    localparam int c_m1_w    = 3;
    localparam int c_m0_w    = 4;
    localparam int c_mode_w  = 3;
    localparam int c_presc_w = 10;

    localparam int c_unit_max_i      = 9;
    localparam int c_min_tens_max_i  = 5;
    localparam int c_hour_max_i      = 23;

    localparam logic [c_m0_w-1:0] c_unit_max       = c_m0_w'(c_unit_max_i);
    localparam logic [c_m1_w-1:0] c_min_tens_max   = c_m1_w'(c_min_tens_max_i);
    localparam logic [c_h1_w-1:0] c_hour_tens_last = c_h1_w'(c_hour_max_i / 10);
    localparam logic [c_h0_w-1:0] c_hour_unit_last = c_h0_w'(c_hour_max_i % 10);

    localparam logic [c_mode_w-1:0] c_st_run    = 3'd0;
    localparam logic [c_mode_w-1:0] c_st_set_h  = 3'd1;
    localparam logic [c_mode_w-1:0] c_st_set_m  = 3'd2;
    localparam logic [c_mode_w-1:0] c_st_set_ah = 3'd3;
    localparam logic [c_mode_w-1:0] c_st_set_am = 3'd4;

    typedef enum logic [1:0] {
        INC_NONE      = 2'd0,
        INC_MIN_CARRY = 2'd1,
        INC_HOUR      = 2'd2,
        INC_MIN       = 2'd3
    } inc_sel_e;

    typedef struct packed {
        logic [c_h1_w-1:0] h1;
        logic [c_h0_w-1:0] h0;
        logic [c_m1_w-1:0] m1;
        logic [c_m0_w-1:0] m0;
    } bcd_time_t;

endpackage

`default_nettype wire

// File: rtl/bcd_time_inc.sv
// ============================================================================
// bcd_time_inc : combinational HH:MM BCD increment (minute+carry/hour/minute)
// Revision     : 1.0
// ============================================================================
`default_nettype none

module bcd_time_inc
    import clock_pkg::*;
(
    input  bcd_time_t time_i,
    input  inc_sel_e  sel_i,
    output bcd_time_t time_o
);

    bcd_time_t w_min_inc;
    bcd_time_t w_hour_inc;
    logic      w_min_carry;

    always_comb begin
        w_min_inc   = time_i;
        w_min_carry = 1'b0;
        if (time_i.m0 == c_unit_max) begin
            w_min_inc.m0 = '0;
            if (time_i.m1 == c_min_tens_max) begin
                w_min_inc.m1 = '0;
                w_min_carry  = 1'b1;
            end else begin
                w_min_inc.m1 = time_i.m1 + 1'b1;
            end
        end else begin
            w_min_inc.m0 = time_i.m0 + 1'b1;
        end
    end

    always_comb begin
        w_hour_inc = time_i;
        if ((time_i.h1 == c_hour_tens_last) && (time_i.h0 == c_hour_unit_last)) begin
            w_hour_inc.h1 = '0;
            w_hour_inc.h0 = '0;
        end else if (time_i.h0 == c_unit_max) begin
            w_hour_inc.h1 = time_i.h1 + 1'b1;
            w_hour_inc.h0 = '0;
        end else begin
            w_hour_inc.h0 = time_i.h0 + 1'b1;
        end
    end

    // Hour-only and minute-only selects leave the other field untouched
    always_comb begin
        time_o = time_i;
        case (sel_i)
            INC_MIN_CARRY: begin
                time_o = w_min_inc;
                if (w_min_carry) begin
                    time_o.h1 = w_hour_inc.h1;
                    time_o.h0 = w_hour_inc.h0;
                end
            end
            INC_HOUR: time_o = w_hour_inc;
            INC_MIN:  time_o = w_min_inc;
            default:  time_o = time_i;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/clock_set_ctrl.sv
// ============================================================================
// clock_set_ctrl : 24h BCD clock with button set modes; optional alarm built
//                  when CLOCK_SET_CTRL_ALARM_EN is defined
// Revision       : 1.0
// ============================================================================
`default_nettype none

module clock_set_ctrl
    import clock_pkg::*;
#(
    parameter int TICK_DIV = 1
) (
    input  logic                clk,
    input  logic                clr,
    input  logic                tick,
    input  logic                mode_btn,
    input  logic                inc_btn,
    input  logic                arm,
    output logic [c_h1_w-1:0]   h1,
    output logic [c_h0_w-1:0]   h0,
    output logic [c_m1_w-1:0]   m1,
    output logic [c_m0_w-1:0]   m0,
    output logic [c_mode_w-1:0] mode,
    output logic                alarm
);

    localparam logic [c_presc_w-1:0] c_presc_last = c_presc_w'(TICK_DIV - 1);

    logic [c_mode_w-1:0]  state_q, state_d;
    logic                 mode_prev_q, inc_prev_q;
    logic [c_presc_w-1:0] presc_q, presc_d;
    bcd_time_t            time_q, time_d;

    logic     w_mode_edge, w_inc_edge, w_inc_take, w_advance;
    logic     w_is_run, w_is_set_h, w_is_set_m;
    inc_sel_e w_time_sel;

    assign w_mode_edge = mode_btn & ~mode_prev_q;
    assign w_inc_edge  = inc_btn & ~inc_prev_q;
    // A mode edge swallows a coincident inc edge
    assign w_inc_take  = w_inc_edge & ~w_mode_edge;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q <= c_st_run;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (w_mode_edge) begin
            case (state_q)
                c_st_run:    state_d = c_st_set_h;
                c_st_set_h:  state_d = c_st_set_m;
`ifdef CLOCK_SET_CTRL_ALARM_EN
                c_st_set_m:  state_d = c_st_set_ah;
                c_st_set_ah: state_d = c_st_set_am;
`endif
                default:     state_d = c_st_run;
            endcase
        end
    end

    always_comb begin
        mode       = state_q;
        w_is_run   = (state_q == c_st_run);
        w_is_set_h = (state_q == c_st_set_h);
        w_is_set_m = (state_q == c_st_set_m);
    end

    // Prescaler only runs in RUN and is forced to 0 whenever RUN is left
    always_comb begin
        presc_d   = presc_q;
        w_advance = 1'b0;
        if (w_is_run && tick) begin
            if (presc_q == c_presc_last) begin
                presc_d   = '0;
                w_advance = 1'b1;
            end else begin
                presc_d = presc_q + 1'b1;
            end
        end
        if (state_d != c_st_run) begin
            presc_d = '0;
        end
    end

    always_comb begin
        w_time_sel = INC_NONE;
        if (w_advance) begin
            w_time_sel = INC_MIN_CARRY;
        end else if (w_is_set_h && w_inc_take) begin
            w_time_sel = INC_HOUR;
        end else if (w_is_set_m && w_inc_take) begin
            w_time_sel = INC_MIN;
        end
    end

    bcd_time_inc u_time_inc (
        .time_i (time_q),
        .sel_i  (w_time_sel),
        .time_o (time_d)
    );

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            mode_prev_q <= 1'b0;
            inc_prev_q  <= 1'b0;
            presc_q     <= '0;
            time_q      <= '0;
        end else begin
            mode_prev_q <= mode_btn;
            inc_prev_q  <= inc_btn;
            presc_q     <= presc_d;
            time_q      <= time_d;
        end
    end

    assign h1 = time_q.h1;
    assign h0 = time_q.h0;
    assign m1 = time_q.m1;
    assign m0 = time_q.m0;

`ifdef CLOCK_SET_CTRL_ALARM_EN
    bcd_time_t alm_q, alm_d;
    logic      alarm_q, alarm_d;
    inc_sel_e  w_alm_sel;
    logic      w_is_set_ah, w_is_set_am;

    assign w_is_set_ah = (state_q == c_st_set_ah);
    assign w_is_set_am = (state_q == c_st_set_am);

    always_comb begin
        w_alm_sel = INC_NONE;
        if (w_is_set_ah && w_inc_take) begin
            w_alm_sel = INC_HOUR;
        end else if (w_is_set_am && w_inc_take) begin
            w_alm_sel = INC_MIN;
        end
    end

    bcd_time_inc u_alm_inc (
        .time_i (alm_q),
        .sel_i  (w_alm_sel),
        .time_o (alm_d)
    );

    // Clearing causes win over a match; every advance re-evaluates the match
    always_comb begin
        alarm_d = alarm_q;
        if (!arm || w_mode_edge || w_inc_edge) begin
            alarm_d = 1'b0;
        end else if (w_advance) begin
            alarm_d = (time_d == alm_q);
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            alm_q   <= '0;
            alarm_q <= 1'b0;
        end else begin
            alm_q   <= alm_d;
            alarm_q <= alarm_d;
        end
    end

    assign alarm = alarm_q;
`else
    logic unused_arm;
    assign unused_arm = arm;
    assign alarm      = 1'b0;
`endif

endmodule

`default_nettype wire
